maze_mem_arbiter: RTL and testbench
===================================

Name: maze_mem_arbiter

Overview:
- Shares the single-port maze memory (16x16 one-bit cells, X/Y addressed, synchronous read) between two requesters: port 0 is the host maze loader (reads and writes), port 1 is the rat solver controller (reads and wall-marking writes).
- Sits between both requesters and the maze memory instance inside the rat top level.
- Arbitration is round-robin, with an optional lock that lets the loader own the memory for a burst.
- A bounded lock timeout prevents the solver from starving.

Parameters:
- COORD_W, 4, width of each X/Y coordinate.
- LOCK_MAX, 64, maximum consecutive grants to a locked owner before forced release (range 1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Req0  in  1  loader request; held until Gnt0.
- Wr0  in  1  loader: 1 = write, 0 = read.
- X0, Y0  in  COORD_W each  loader cell address.
- Din0  in  1  loader write data.
- Lock0  in  1  loader burst lock; sampled when Gnt0 is issued.
- Gnt0  out  1  one-cycle grant pulse; memory access occurs this cycle.
- Valid0  out  1  one-cycle read-data-valid pulse.
- Rdata0  out  1  read data, meaningful only while Valid0 is high.
- Req1, Wr1, X1, Y1, Din1, Gnt1, Valid1, Rdata1: same as port 0, for the solver. The solver has no lock.
- Mem_X, Mem_Y  out  COORD_W each  memory address.
- Mem_Rd  out  1  memory read strobe.
- Mem_Wr  out  1  memory write strobe.
- Mem_Din  out  1  memory write data.
- Mem_Dout  in  1  memory read data, valid the cycle after Mem_Rd.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, Rst=1):
  - State = IDLE; rr pointer = 0 (port 0 favoured next); lock_owner cleared; lock counter = 0.
  - All of Gnt*, Valid*, Rdata*, Mem_Rd, Mem_Wr, Mem_Din, Mem_X, Mem_Y and Busy are 0.
  - A reset mid-access drops any in-flight read: no Valid pulse is issued and no pending write occurs after reset.
- States:
  - IDLE: no access in progress.
  - ACCESS: one cycle; memory strobes driven from the latched request.
  - RESP: one cycle; read data returned to the requester.
- Selection, evaluated in IDLE and in RESP:
  - If lock_owner is set and Req0=1, choose port 0.
  - Otherwise, if only one Req is high, choose that port.
  - If both Req are high, choose the port named by rr.
  - On selection, latch the port, Wr, X, Y and Din; the next state is ACCESS.
  - If neither Req is high, the next state is IDLE.
- ACCESS cycle:
  - Mem_X/Mem_Y carry the latched address; Mem_Rd = !Wr and Mem_Wr = Wr for exactly this cycle.
  - Gnt of the selected port pulses for this cycle.
  - rr is set to the other port.
  - A write goes next to IDLE; a read goes next to RESP.
- RESP cycle:
  - Valid of the read's port = 1 and Rdata = Mem_Dout.
  - Selection runs in the same cycle, so back-to-back reads cost 2 cycles each.
  - Writes cost 2 cycles each (ACCESS + IDLE).
- Latency: request seen in IDLE at cycle t gives Gnt at t+1 and, for a read, Valid at t+2.
- Lock:
  - On a Gnt0 with Lock0=1: lock_owner is set and the lock counter increments.
  - On a Gnt0 with Lock0=0: lock_owner is cleared and the counter resets to 0.
  - When the counter reaches LOCK_MAX: lock_owner is forcibly cleared and the counter resets; the next selection follows rr (port 1 wins if requesting).
  - While locked with Req0=0 and Req1=1, port 1 is served; lock_owner is retained.
- Requester contract: Req, Wr, X, Y and Din are stable from assertion until Gnt. A requester may drop Req in the Gnt cycle or keep it for back-to-back access. Changing inputs before Gnt is a protocol violation; the arbiter takes whatever values it samples.
- Simultaneous events: Gnt0 and Gnt1 are never high in the same cycle; neither are Valid0 and Valid1; Mem_Rd and Mem_Wr are mutually exclusive.
- Address width: X and Y are passed through unmodified, with no wrap-around or bounds arithmetic.

Test Plan:
- Reset values: assert Rst mid-read (during ACCESS) → all outputs are 0 immediately (asynchronous); no Valid after release; Busy=0.
- Single read latency: Req1=1, Wr1=0, X1=3, Y1=5, memory cell (3,5)=1 → Gnt1 at t+1 with Mem_Rd=1, Mem_X=3, Mem_Y=5; Valid1=1 and Rdata1=1 at t+2.
- Round-robin contention: Req0 and Req1 held high as reads from reset → grants go 0,1,0,1, one grant every 2 cycles; never two Gnts in the same cycle.
- Write then read-back: port 0 writes Din0=1 at (15,15), then port 1 reads (15,15) → Mem_Wr pulse with Mem_Din=1, then Rdata1=1.
- Lock burst with LOCK_MAX=4: Req0 held with Lock0=1 and Req1 held high → exactly 4 consecutive Gnt0, then Gnt1, then Gnt0 again.
- Locked owner idle: lock set, Req0 dropped, Req1=1 → Gnt1 issued; lock_owner retained, so Req0 wins when reasserted alongside Req1.

Source files
------------

// File: rtl/maze_mem_arbiter_if.sv
// Request/grant bus between the maze loader, the rat solver, the maze memory and the arbiter.
// slave is the arbiter's view; master is the surrounding requesters plus memory.
interface maze_mem_arbiter_if #(
  parameter int unsigned COORD_W = 4
);
  logic               req0;
  logic               wr0;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic               din0;
  logic               lock0;
  logic               gnt0;
  logic               valid0;
  logic               rdata0;

  logic               req1;
  logic               wr1;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               din1;
  logic               gnt1;
  logic               valid1;
  logic               rdata1;

  logic [COORD_W-1:0] mem_x;
  logic [COORD_W-1:0] mem_y;
  logic               mem_rd;
  logic               mem_wr;
  logic               mem_din;
  logic               mem_dout;
  logic               busy;

  modport slave (
    input  req0, wr0, x0, y0, din0, lock0,
    output gnt0, valid0, rdata0,
    input  req1, wr1, x1, y1, din1,
    output gnt1, valid1, rdata1,
    output mem_x, mem_y, mem_rd, mem_wr, mem_din,
    input  mem_dout,
    output busy
  );

  modport master (
    output req0, wr0, x0, y0, din0, lock0,
    input  gnt0, valid0, rdata0,
    output req1, wr1, x1, y1, din1,
    input  gnt1, valid1, rdata1,
    input  mem_x, mem_y, mem_rd, mem_wr, mem_din,
    output mem_dout,
    input  busy
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze memory between the loader (port 0)
// and the rat solver (port 1), with a bounded burst lock for the loader.
module maze_mem_arbiter #(
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned LOCK_MAX = 64
) (
  input logic               clk,
  input logic               rst,
  maze_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sel_any;
  logic               sel_port;
  logic               rr;
  logic               lock_owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               lat_port;
  logic               lat_wr;
  logic               lat_din;
  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // port selection: locked loader first, then a lone requester, then round-robin
  always_comb begin
    sel_any  = 1'b0;
    sel_port = 1'b0;
    if (state != ACCESS) begin
      if (lock_owner && bus.req0) begin
        sel_any  = 1'b1;
        sel_port = 1'b0;
      end else if (bus.req0 && bus.req1) begin
        sel_any  = 1'b1;
        sel_port = rr;
      end else if (bus.req0) begin
        sel_any  = 1'b1;
        sel_port = 1'b0;
      end else if (bus.req1) begin
        sel_any  = 1'b1;
        sel_port = 1'b1;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = sel_any ? ACCESS : IDLE;
      ACCESS:  state_nxt = lat_wr ? IDLE : RESP;
      RESP:    state_nxt = sel_any ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winning request so the memory cycle does not depend on live inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_port <= 1'b0;
      lat_wr   <= 1'b0;
      lat_din  <= 1'b0;
      lat_x    <= '0;
      lat_y    <= '0;
    end else if (sel_any) begin
      lat_port <= sel_port;
      lat_wr   <= sel_port ? bus.wr1  : bus.wr0;
      lat_din  <= sel_port ? bus.din1 : bus.din0;
      lat_x    <= sel_port ? bus.x1   : bus.x0;
      lat_y    <= sel_port ? bus.y1   : bus.y0;
    end
  end

  assign cnt_inc = lock_cnt + CNT_W'(1);

  // round-robin pointer and lock bookkeeping, updated once per grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr         <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (state == ACCESS) begin
      rr <= ~lat_port;
      if (!lat_port) begin
        if (bus.lock0) begin
          if (cnt_inc == CNT_W'(LOCK_MAX)) begin
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
          end else begin
            lock_owner <= 1'b1;
            lock_cnt   <= cnt_inc;
          end
        end else begin
          lock_owner <= 1'b0;
          lock_cnt   <= '0;
        end
      end
    end
  end

  // outputs decoded from the state register and the latched request
  always_comb begin
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    bus.valid0  = 1'b0;
    bus.valid1  = 1'b0;
    bus.rdata0  = 1'b0;
    bus.rdata1  = 1'b0;
    bus.mem_x   = '0;
    bus.mem_y   = '0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mem_din = 1'b0;
    bus.busy    = (state != IDLE);
    case (state)
      ACCESS: begin
        bus.gnt0    = ~lat_port;
        bus.gnt1    = lat_port;
        bus.mem_x   = lat_x;
        bus.mem_y   = lat_y;
        bus.mem_rd  = ~lat_wr;
        bus.mem_wr  = lat_wr;
        bus.mem_din = lat_din;
      end
      RESP: begin
        bus.valid0 = ~lat_port;
        bus.valid1 = lat_port;
        bus.rdata0 = ~lat_port & bus.mem_dout;
        bus.rdata1 = lat_port & bus.mem_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed vector table, contention/lock sequences,
// and randomized traffic checked against a transaction-level memory model.
module tb_maze_mem_arbiter;

  localparam int unsigned COORD_W  = 4;
  localparam int unsigned LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  maze_mem_arbiter_if #(.COORD_W(COORD_W)) bus ();

  maze_mem_arbiter #(.COORD_W(COORD_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // maze memory instance: synchronous read, data valid the cycle after mem_rd
  logic cells [256];
  always @(posedge clk) begin
    if (bus.mem_wr) cells[{bus.mem_y, bus.mem_x}] <= bus.mem_din;
    if (bus.mem_rd) bus.mem_dout <= cells[{bus.mem_y, bus.mem_x}];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic p, input logic req, input logic wr,
                          input logic [3:0] x, input logic [3:0] y, input logic din);
    if (!p) begin
      bus.req0 = req; bus.wr0 = wr; bus.x0 = x; bus.y0 = y; bus.din0 = din;
    end else begin
      bus.req1 = req; bus.wr1 = wr; bus.x1 = x; bus.y1 = y; bus.din1 = din;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".gnt0"}, bus.gnt0, 1'b0);
    chk({name, ".gnt1"}, bus.gnt1, 1'b0);
    chk({name, ".valid0"}, bus.valid0, 1'b0);
    chk({name, ".valid1"}, bus.valid1, 1'b0);
    chk({name, ".rdata0"}, bus.rdata0, 1'b0);
    chk({name, ".rdata1"}, bus.rdata1, 1'b0);
    chk({name, ".mem_rd"}, bus.mem_rd, 1'b0);
    chk({name, ".mem_wr"}, bus.mem_wr, 1'b0);
    chk({name, ".mem_din"}, bus.mem_din, 1'b0);
    chk4({name, ".mem_x"}, bus.mem_x, 4'd0);
    chk4({name, ".mem_y"}, bus.mem_y, 4'd0);
    chk({name, ".busy"}, bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    bus.lock0 = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
  endtask

  // wait for the next grant; port = -1 if none arrives within the bound
  task automatic expect_grant(output int port, output int cycles);
    port   = -1;
    cycles = 0;
    while (cycles < 8) begin
      tick();
      cycles++;
      chk("gnt_exclusive", bus.gnt0 & bus.gnt1, 1'b0);
      if (bus.gnt0) begin port = 0; break; end
      if (bus.gnt1) begin port = 1; break; end
    end
  endtask

  typedef struct {
    logic       port;
    logic       wr;
    logic [3:0] x;
    logic [3:0] y;
    logic       din;
    logic       rdata;
  } vec_t;

  vec_t vecs [10];

  // randomized-phase model: outstanding request per port and known memory contents
  logic       pend [2];
  logic       p_wr [2];
  logic [3:0] p_x [2];
  logic [3:0] p_y [2];
  logic       p_din [2];
  int         wait_cnt [2];
  logic       exp_valid [2];
  logic       exp_rdata [2];
  logic       exp_known [2];
  logic       ref_mem [256];
  logic       ref_known [256];

  initial begin
    int gp;
    int gc;
    int lock_seq [6];
    int lock_tail [5];
    for (int i = 0; i < 256; i++) cells[i] = 1'b0;
    do_reset();

    // directed single transactions, one port at a time, on an idle arbiter
    vecs[0] = '{1'b0, 1'b1, 4'd3,  4'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd3,  4'd5,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'd15, 4'd0,  1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  4'd15, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd15, 4'd0,  1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'd3,  4'd5,  1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 4'd3,  4'd5,  1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      int n;
      set_port(vecs[i].port, 1'b1, vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].din);
      tick();
      chk("vec.gnt0", bus.gnt0, ~vecs[i].port);
      chk("vec.gnt1", bus.gnt1, vecs[i].port);
      chk("vec.mem_rd", bus.mem_rd, ~vecs[i].wr);
      chk("vec.mem_wr", bus.mem_wr, vecs[i].wr);
      chk4("vec.mem_x", bus.mem_x, vecs[i].x);
      chk4("vec.mem_y", bus.mem_y, vecs[i].y);
      if (vecs[i].wr) chk("vec.mem_din", bus.mem_din, vecs[i].din);
      set_port(vecs[i].port, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      chk("vec.valid0", bus.valid0, ~vecs[i].port & ~vecs[i].wr);
      chk("vec.valid1", bus.valid1, vecs[i].port & ~vecs[i].wr);
      chk("vec.busy", bus.busy, ~vecs[i].wr);
      if (!vecs[i].wr)
        chk("vec.rdata", vecs[i].port ? bus.rdata1 : bus.rdata0, vecs[i].rdata);
      n = 0;
      while (bus.busy && n < 4) begin tick(); n++; end
      chk("vec.idle", bus.busy, 1'b0);
    end

    // asynchronous reset during the ACCESS cycle of a read
    set_port(1'b1, 1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    tick();
    chk("rstmid.gnt1_before", bus.gnt1, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("rstmid");
    set_port(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid.no_valid1", bus.valid1, 1'b0);
      chk("rstmid.busy", bus.busy, 1'b0);
    end

    // round-robin with both ports reading continuously from reset
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
    set_port(1'b1, 1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expect_grant(gp, gc);
      chk_int("rr.port", gp, k % 2);
      chk_int("rr.spacing", gc, (k == 0) ? 1 : 2);
    end
    set_port(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (3) tick();

    // lock burst: LOCK_MAX grants to the loader, then the solver, then loader again
    do_reset();
    bus.lock0 = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b0);
    set_port(1'b1, 1'b1, 1'b0, 4'd8, 4'd8, 1'b0);
    lock_seq = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      expect_grant(gp, gc);
      chk_int("lock.burst", gp, lock_seq[k]);
    end
    // owner goes quiet: solver served, lock and its count survive
    bus.req0 = 1'b0;
    lock_tail = '{1, 0, 0, 0, 1};
    for (int k = 0; k < 5; k++) begin
      expect_grant(gp, gc);
      chk_int("lock.idle_owner", gp, lock_tail[k]);
      if (k == 0) bus.req0 = 1'b1;
    end
    set_port(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    bus.lock0 = 1'b0;
    repeat (3) tick();

    // randomized traffic against the transaction model
    do_reset();
    for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; wait_cnt[p] = 0; exp_valid[p] = 1'b0;
      exp_rdata[p] = 1'b0; exp_known[p] = 1'b0;
      p_wr[p] = 1'b0; p_x[p] = 4'd0; p_y[p] = 4'd0; p_din[p] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic granted [2];
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]     = 1'b1;
          wait_cnt[p] = 0;
          p_wr[p]     = 1'($urandom_range(0, 1));
          p_x[p]      = 4'($urandom_range(0, 15));
          p_y[p]      = 4'($urandom_range(0, 15));
          p_din[p]    = 1'($urandom_range(0, 1));
          set_port(1'(p), 1'b1, p_wr[p], p_x[p], p_y[p], p_din[p]);
          if (p == 0) bus.lock0 = 1'($urandom_range(0, 1));
        end
      end
      tick();
      if (bus.gnt0 & bus.gnt1) chk("rnd.gnt_exclusive", 1'b1, 1'b0);
      if (bus.valid0 & bus.valid1) chk("rnd.valid_exclusive", 1'b1, 1'b0);
      if (bus.mem_rd & bus.mem_wr) chk("rnd.strobe_exclusive", 1'b1, 1'b0);
      chk("rnd.valid0", bus.valid0, exp_valid[0]);
      chk("rnd.valid1", bus.valid1, exp_valid[1]);
      if (exp_valid[0] && exp_known[0]) chk("rnd.rdata0", bus.rdata0, exp_rdata[0]);
      if (exp_valid[1] && exp_known[1]) chk("rnd.rdata1", bus.rdata1, exp_rdata[1]);
      for (int p = 0; p < 2; p++) begin
        granted[p]   = (p == 0) ? bus.gnt0 : bus.gnt1;
        exp_valid[p] = 1'b0;
        if (granted[p]) begin
          chk("rnd.gnt_pending", pend[p], 1'b1);
          chk4("rnd.mem_x", bus.mem_x, p_x[p]);
          chk4("rnd.mem_y", bus.mem_y, p_y[p]);
          chk("rnd.mem_wr", bus.mem_wr, p_wr[p]);
          chk("rnd.mem_rd", bus.mem_rd, ~p_wr[p]);
          if (p_wr[p]) begin
            chk("rnd.mem_din", bus.mem_din, p_din[p]);
            ref_mem[{p_y[p], p_x[p]}]   = p_din[p];
            ref_known[{p_y[p], p_x[p]}] = 1'b1;
          end else begin
            exp_valid[p] = 1'b1;
            exp_rdata[p] = ref_mem[{p_y[p], p_x[p]}];
            exp_known[p] = ref_known[{p_y[p], p_x[p]}];
          end
          pend[p] = 1'b0;
          set_port(1'(p), 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        end else if (pend[p]) begin
          wait_cnt[p]++;
          if (wait_cnt[p] == 20) chk_int("rnd.starvation", wait_cnt[p], 0);
        end
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
